// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared state encoding, index width and accumulate helpers for the FIR MAC
package fir_pkg;

    typedef logic [1:0] fir_state_t;

    localparam fir_state_t ST_IDLE = 2'd0;
    localparam fir_state_t ST_MAC  = 2'd1;
    localparam fir_state_t ST_DONE = 2'd2;

    function automatic int tap_idx_w(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

    // Sum is formed one bit wider than any supported accumulator so the carry is visible for clamping.
    function automatic logic [63:0] acc_add(input logic [63:0] acc, input logic [63:0] prod,
                                            input int acc_w, input bit sat);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, acc} + {1'b0, prod};
        lim = (65'd1 << acc_w) - 65'd1;
        if (sat && (sum > lim)) begin
            return lim[63:0];
        end
        return sum[63:0] & lim[63:0];
    endfunction

endpackage

// File: rtl/fir_coef_regfile.sv
// rtl/fir_coef_regfile.sv - run-time writable per-tap coefficient registers with a combinational read port
module fir_coef_regfile #(
    parameter int TAPS      = 6,
    parameter int COEF_W    = 8,
    parameter int COEF_INIT = 2,
    parameter int AW        = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [COEF_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [COEF_W-1:0] rdata_o
);

    logic [COEF_W-1:0] coef_q [TAPS];

    // Address decode by compare so indices >= TAPS match nothing and are dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < TAPS; i++) begin
                coef_q[i] <= COEF_W'(COEF_INIT);
            end
        end else if (we_i) begin
            for (int i = 0; i < TAPS; i++) begin
                if (waddr_i == AW'(i)) begin
                    coef_q[i] <= wdata_i;
                end
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < TAPS; i++) begin
            if (raddr_i == AW'(i)) begin
                rdata_o = coef_q[i];
            end
        end
    end

endmodule

// File: rtl/fir_tdm_mac.sv
// rtl/fir_tdm_mac.sv - time-multiplexed FIR engine: one shared multiplier, one output per accepted sample
module fir_tdm_mac
    import fir_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int TAPS      = 6,
    parameter int ACC_W     = 20,
    parameter int SAT       = 0,
    parameter int COEF_INIT = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 coef_we_i,
    input  logic [fir_pkg::tap_idx_w(TAPS)-1:0]  coef_addr_i,
    input  logic [COEF_W-1:0]                    coef_wdata_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic [DATA_W-1:0]                    in_data_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [ACC_W-1:0]                     out_data_o
);

    localparam int AW = tap_idx_w(TAPS);
    localparam int PW = DATA_W + COEF_W;

    fir_state_t        state_q, state_d;
    logic [DATA_W-1:0] tap_q [TAPS];
    logic [DATA_W-1:0] tap_d [TAPS];
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [AW-1:0]     k_q, k_d;

    logic [COEF_W-1:0] coef_k;
    logic [PW-1:0]     prod;
    logic [ACC_W-1:0]  acc_next;
    logic              in_fire;
    logic              out_fire;
    logic              last_tap;

    assign in_ready_o  = (state_q == ST_IDLE) && !rst_i;
    assign in_fire     = in_valid_i && in_ready_o;
    assign out_fire    = out_valid_q && out_ready_i;
    assign last_tap    = (k_q == AW'(TAPS - 1));
    assign prod        = PW'(coef_k) * PW'(tap_q[k_q]);
    assign acc_next    = ACC_W'(acc_add(64'(acc_q), 64'(prod), ACC_W, SAT != 0));
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

    // Writes only land in IDLE so a running sum never mixes coefficient sets.
    fir_coef_regfile #(
        .TAPS      (TAPS),
        .COEF_W    (COEF_W),
        .COEF_INIT (COEF_INIT),
        .AW        (AW)
    ) u_coef (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (coef_we_i && (state_q == ST_IDLE)),
        .waddr_i (coef_addr_i),
        .wdata_i (coef_wdata_i),
        .raddr_i (k_q),
        .rdata_o (coef_k)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        k_d         = k_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        for (int i = 0; i < TAPS; i++) begin
            tap_d[i] = tap_q[i];
        end
        case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    tap_d[0] = in_data_i;
                    for (int i = 1; i < TAPS; i++) begin
                        tap_d[i] = tap_q[i-1];
                    end
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_next;
                k_d   = k_q + AW'(1);
                if (last_tap) begin
                    out_data_d  = acc_next;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < TAPS; i++) begin
                tap_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            for (int i = 0; i < TAPS; i++) begin
                tap_q[i] <= tap_d[i];
            end
        end
    end

endmodule
